// File: rtl/dcim_out_quant.sv
// Output quantizer for the digital CIM macro: bias add, arithmetic shift, saturate, optional ReLU, small output FIFO.
// Optional build macro DCIM_OUT_ROUND_EN selects round-half-up instead of floor truncation.
module dcim_out_quant #(
   parameter int ACC_WIDTH  = 51,
   parameter int OUT_WIDTH  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ACC_WIDTH-1:0] nout,
   input  logic                 op_done,
   input  logic [ACC_WIDTH-1:0] bias,
   input  logic [5:0]           shift,
   input  logic                 relu_en,
   output logic [OUT_WIDTH-1:0] q_data,
   output logic                 q_valid,
   input  logic                 q_ready,
   output logic                 overflow,
   output logic                 sat
);

   localparam int SUM_W = ACC_WIDTH + 1;
   localparam int EXT_W = ACC_WIDTH + 2;
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic signed [EXT_W-1:0] Q_MAX =
      {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] Q_MIN =
      {{(EXT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
   localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

   // Stage 1: bias add, sampled alongside the per-op shift and ReLU controls
   logic                    s1_valid;
   logic signed [SUM_W-1:0] s1_sum;
   logic [5:0]              s1_shift;
   logic                    s1_relu;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sum   <= '0;
         s1_shift <= '0;
         s1_relu  <= 1'b0;
      end else begin
         s1_valid <= op_done;
         if (op_done) begin
            s1_sum   <= {nout[ACC_WIDTH-1], nout} + {bias[ACC_WIDTH-1], bias};
            s1_shift <= shift;
            s1_relu  <= relu_en;
         end
      end
   end

   // Stage 2 datapath: one extra bit of headroom so the rounding add cannot wrap
   logic signed [EXT_W-1:0] s2_ext;
   logic signed [EXT_W-1:0] s2_rnd;
   logic signed [EXT_W-1:0] s2_shifted;
   logic [OUT_WIDTH-1:0]    s2_next;
   logic                    s2_clip;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      s2_ext     = {s1_sum[SUM_W-1], s1_sum};
      s2_rnd     = s2_ext;
      s2_shifted = '0;
      s2_next    = '0;
      s2_clip    = 1'b0;

`ifdef DCIM_OUT_ROUND_EN
      if (s1_shift != 6'd0) begin
         s2_rnd = s2_ext + (EXT_W'(1) << (s1_shift - 6'd1));
      end
`else
      s2_rnd = s2_ext;
`endif

      s2_shifted = s2_rnd >>> s1_shift;

      if (s2_shifted > Q_MAX) begin
         s2_next = Q_MAX[OUT_WIDTH-1:0];
         s2_clip = 1'b1;
      end else if (s2_shifted < Q_MIN) begin
         s2_next = Q_MIN[OUT_WIDTH-1:0];
         s2_clip = 1'b1;
      end else begin
         s2_next = s2_shifted[OUT_WIDTH-1:0];
      end

      // ReLU runs after saturation and does not count as clipping
      if (s1_relu && s2_next[OUT_WIDTH-1]) begin
         s2_next = '0;
      end
   end

   logic                 s2_valid;
   logic [OUT_WIDTH-1:0] s2_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
         sat      <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_data <= s2_next;
         end
         if (s1_valid && s2_clip) begin
            sat <= 1'b1;
         end
      end
   end

   // Output FIFO: pointers carry one extra wrap bit to tell full from empty
   logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W:0]       wr_ptr;
   logic [PTR_W:0]       rd_ptr;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 do_pop;
   logic                 do_push;
   logic                 do_drop;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign do_pop     = q_valid && q_ready;
   assign do_push    = s2_valid && (!fifo_full || do_pop);
   assign do_drop    = s2_valid && fifo_full && !do_pop;

   assign q_valid = !fifo_empty;
   assign q_data  = fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (do_drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // NOTE: storage has no reset; emptiness is tracked by the pointers and q_data is forced to 0 when empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[PTR_W-1:0]] <= s2_data;
      end
   end

endmodule

// File: tb/tb_dcim_out_quant.sv
// Self-checking bench for dcim_out_quant (default parameters); expected values follow DCIM_OUT_ROUND_EN when defined.
module tb_dcim_out_quant;

   logic        clk = 1'b0;
   logic        rst;
   logic [50:0] nout;
   logic        op_done;
   logic [50:0] bias;
   logic [5:0]  shift;
   logic        relu_en;
   logic [7:0]  q_data;
   logic        q_valid;
   logic        q_ready;
   logic        overflow;
   logic        sat;

   int n_checks = 0;
   int n_fail   = 0;
   longint sb[$];

   dcim_out_quant dut (
      .clk      (clk),
      .rst      (rst),
      .nout     (nout),
      .op_done  (op_done),
      .bias     (bias),
      .shift    (shift),
      .relu_en  (relu_en),
      .q_data   (q_data),
      .q_valid  (q_valid),
      .q_ready  (q_ready),
      .overflow (overflow),
      .sat      (sat)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint model(longint n, longint b, int sh, bit relu);
      longint s;
      s = n + b;
`ifdef DCIM_OUT_ROUND_EN
      if (sh > 0) s = s + (longint'(1) << (sh - 1));
`endif
      s = s >>> sh;
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
      if (relu && s < 0) s = 0;
      return s;
   endfunction

   task automatic drive_op(input longint n, input longint b, input int sh, input bit relu);
      nout    = 51'(n);
      bias    = 51'(b);
      shift   = 6'(sh);
      relu_en = relu;
      op_done = 1'b1;
   endtask

   // Compare the FIFO head against the scoreboard head (caller arranges the pop)
   task automatic check_head(input string tag);
      if (sb.size() == 0) begin
         check({tag, "_sb_underflow"}, 64'sd1, 64'sd0);
      end else begin
         check(tag, $signed(q_data), sb.pop_front());
      end
   endtask

   // One op with q_ready high: checks 3-cycle latency, value and single-entry pop
   task automatic single(input string tag, input longint n, input longint b,
                         input int sh, input bit relu, input longint exp);
      q_ready = 1'b1;
      drive_op(n, b, sh, relu);
      sb.push_back(exp);
      tick();
      op_done = 1'b0;
      check({tag, "_valid_c1"}, q_valid, 0);
      tick();
      check({tag, "_valid_c2"}, q_valid, 0);
      tick();
      check({tag, "_valid_c3"}, q_valid, 1);
      check_head({tag, "_data"});
      tick();
      check({tag, "_valid_after_pop"}, q_valid, 0);
   endtask

   // Pop one entry, waiting a bounded number of cycles for it to appear
   task automatic drain_one(input string tag);
      int waited = 0;
      q_ready = 1'b0;
      while (!q_valid && waited < 20) begin
         tick();
         waited++;
      end
      check({tag, "_present"}, q_valid, 1);
      check_head(tag);
      q_ready = 1'b1;
      tick();
      q_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; op_done = 1'b0; q_ready = 1'b0;
      nout = '0; bias = '0; shift = '0; relu_en = 1'b0;

      // Reset, with an op_done coinciding with the last reset cycle
      tick(); tick();
      drive_op(77, 0, 0, 1'b0);
      tick();
      rst = 1'b0; op_done = 1'b0;
      check("rst_q_valid", q_valid, 0);
      check("rst_q_data", $signed(q_data), 0);
      check("rst_overflow", overflow, 0);
      check("rst_sat", sat, 0);
      repeat (4) tick();
      check("op_in_reset_ignored", q_valid, 0);

      // Directed rounding / ReLU / saturation points
`ifdef DCIM_OUT_ROUND_EN
      single("pos_round", 1004, 0, 3, 1'b0, 126);
      single("neg_round", -1000, 0, 4, 1'b0, -62);
`else
      single("pos_round", 1004, 0, 3, 1'b0, 125);
      single("neg_round", -1000, 0, 4, 1'b0, -63);
`endif
      single("neg_relu", -1000, 0, 4, 1'b1, 0);
      check("sat_clear_before_clip", sat, 0);
      single("mixed_bias", 37, -5, 1, 1'b0, model(37, -5, 1, 1'b0));
      single("pos_sat", 100000, -50, 0, 1'b0, 127);
      check("sat_set", sat, 1);
      single("neg_sat", -100000, 0, 0, 1'b0, -128);
      single("big_shift", 51'sh3_ffff_ffff_fff0, 0, 50, 1'b0,
             model(51'sh3_ffff_ffff_fff0, 0, 50, 1'b0));

      // Overflow: six back-to-back ops into a stalled FIFO of depth 4
      q_ready = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         drive_op(i, 0, 0, 1'b0);
         if (i <= 4) sb.push_back(i);
         tick();
      end
      op_done = 1'b0;
      check("ovf_not_yet", overflow, 0);
      tick();
      check("ovf_set", overflow, 1);
      tick(); tick();
      for (int i = 0; i < 4; i++) drain_one($sformatf("ovf_drain%0d", i));
      check("ovf_empty_after_drain", q_valid, 0);
      check("ovf_sticky", overflow, 1);
      check("sat_sticky", sat, 1);

      // Reset one cycle after a (saturating) op: it must vanish
      drive_op(100000, 0, 0, 1'b0);
      tick();
      op_done = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_q_valid", q_valid, 0);
      check("midrst_overflow", overflow, 0);
      check("midrst_sat", sat, 0);
      repeat (4) tick();
      check("midrst_no_entry", q_valid, 0);
      check("midrst_sat_stays", sat, 0);

      // Full FIFO with simultaneous push and pop every cycle
      for (int c = 0; c < 12; c++) begin
         drive_op(20 + c, c, 1, c[0]);
         sb.push_back(model(20 + c, c, 1, c[0]));
         q_ready = (c >= 6);
         if (c >= 6) begin
            check($sformatf("stream_full_c%0d", c), q_valid, 1);
            check_head($sformatf("stream_c%0d", c));
         end
         tick();
      end
      op_done = 1'b0;
      q_ready = 1'b1;
      for (int w = 0; w < 30 && sb.size() > 0; w++) begin
         if (q_valid) check_head($sformatf("stream_tail%0d", w));
         tick();
      end
      check("stream_all_drained", sb.size(), 0);
      check("stream_empty", q_valid, 0);
      check("stream_no_overflow", overflow, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dcim_out_quant.md
DCIM_OUT_QUANT -- requirements
Module: dcim_out_quant

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter ACC_WIDTH, default 51, SHALL set the accumulator input width.
REQ-003 Parameter OUT_WIDTH, default 8, SHALL set the quantized output width.
REQ-004 Parameter FIFO_DEPTH, default 4 (power of two, at least 2), SHALL set the number of output FIFO entries.
REQ-005 Port clk, input, 1 bit, SHALL be the clock; all logic is rising-edge.
REQ-006 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-007 Port nout, input, ACC_WIDTH bits, SHALL carry the macro accumulator result as two's complement.
REQ-008 Port op_done, input, 1 bit, SHALL be a one-cycle pulse marking nout as valid in the same cycle.
REQ-009 Port bias, input, ACC_WIDTH bits, SHALL be a signed bias added to nout.
REQ-010 Port shift, input, 6 bits, SHALL be the right-shift amount, range 0..50.
REQ-011 Port relu_en, input, 1 bit, SHALL clamp negative results to 0 when high.
REQ-012 Port q_data, output, OUT_WIDTH bits, SHALL be the FIFO head, signed.
REQ-013 Port q_valid, output, 1 bit, SHALL be high whenever the FIFO is non-empty.
REQ-014 Port q_ready, input, 1 bit, SHALL cause a pop when high together with q_valid.
REQ-015 Port overflow, output, 1 bit, SHALL be a sticky flag for a result dropped because the FIFO was full.
REQ-016 Port sat, output, 1 bit, SHALL be a sticky flag for any result clipped by saturation (ReLU clamping excluded).

Function
REQ-017 Stage 1 SHALL register on op_done: sum = sext(nout) + sext(bias), ACC_WIDTH+1 bits, plus shift and relu_en sampled in the same cycle.
REQ-018 Stage 2 SHALL arithmetic-right-shift sum by shift and apply the rounding rule of REQ-031/REQ-032.
- Intermediate width SHALL be ACC_WIDTH+2 bits so the rounding add cannot overflow.
REQ-019 Stage 2 SHALL saturate the shifted value to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and set sat when clipping occurs.
REQ-020 After saturation, if relu_en was high, negative results SHALL become 0.
REQ-021 The FIFO push SHALL occur 2 cycles after op_done; q_valid SHALL rise on the following cycle when the FIFO was empty.
REQ-022 Back-to-back op_done pulses on consecutive cycles SHALL each produce one FIFO entry, in order.
REQ-023 A push while the FIFO is full and no pop occurs in the same cycle SHALL drop the result and set overflow; FIFO contents SHALL be unchanged.
REQ-024 A simultaneous push and pop while the FIFO is full SHALL both succeed; overflow SHALL remain unchanged.
REQ-025 A simultaneous push and pop while the FIFO is empty SHALL only push; the pop is ignored because q_valid is 0.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL use one extra pointer bit.
REQ-027 q_data SHALL hold its value while q_valid is high and q_ready is low.

Reset
REQ-028 On rst high at a clock edge, the block SHALL:
- clear the pipeline valid bits, so in-flight results are discarded;
- empty the FIFO;
- drive q_valid=0, q_data=0, overflow=0 and sat=0.
REQ-029 An op_done arriving in the same cycle as rst SHALL be ignored.
REQ-030 overflow and sat SHALL clear only on reset.

Configuration
REQ-031 When macro DCIM_OUT_ROUND_EN is defined, stage 2 SHALL add 2^(shift-1) before shifting when shift > 0, giving round-half-up.
REQ-032 When DCIM_OUT_ROUND_EN is not defined, stage 2 SHALL shift only, giving floor truncation, and SHALL contain no rounding adder.

Verification
REQ-033 nout=1004, bias=0, shift=3, relu_en=0, q_ready=1 -> q_data=126 with ROUND_EN, 125 without; q_valid 3 cycles after op_done.
REQ-034 nout=-1000, bias=0, shift=4 -> q_data=-62 with ROUND_EN, -63 without; same stimulus with relu_en=1 -> q_data=0 and sat=0.
REQ-035 nout=100000, bias=-50, shift=0 -> q_data=127 and sat=1; nout=-100000 -> q_data=-128.
REQ-036 q_ready=0 and six op_done pulses with nout=1..6, shift=0 -> FIFO holds 1,2,3,4; overflow=1; draining yields 1,2,3,4 then q_valid=0.
REQ-037 FIFO full with q_ready=1 and op_done every cycle -> no drops, overflow stays 0, output order preserved.
REQ-038 rst asserted one cycle after op_done -> no entry appears; q_valid=0, overflow=0 and sat=0 the cycle after reset.
